// File: rtl/tlc_pkg.sv
// tlc_pkg: lamp codes and phase encoding shared by the traffic light controller
package tlc_pkg;
  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  typedef enum logic [1:0] {PH_GREEN = 2'd0, PH_YELLOW = 2'd1, PH_ALLRED = 2'd2} phase_t;
endpackage

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick: first set request at start, start+1, ... (mod N), else default index
module tlc_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic [W-1:0] dflt,
  output logic [W-1:0] grant,
  output logic         valid
);
  always_comb begin
    grant = dflt;
    valid = 1'b0;
    // scan from farthest to nearest so the nearest request wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N]) begin
        grant = W'((int'(start) + k) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/multi_approach_tlc.sv
// multi_approach_tlc: N-approach round-robin traffic light controller with demand latches
module multi_approach_tlc
  import tlc_pkg::*;
#(
  parameter int N_APPR = 4,
  parameter int HOME = 0,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int Y2R_DELAY = 3,
  parameter int R2G_DELAY = 2,
  parameter int TW = 8
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic [N_APPR-1:0]           sensor,
  output logic [2*N_APPR-1:0]         lights,
  output logic [$clog2(N_APPR)-1:0]   active,
  output logic [1:0]                  phase,
  output logic [N_APPR-1:0]           demand
);
  localparam int AW = $clog2(N_APPR);
  localparam logic [AW-1:0] HOME_I = AW'(HOME);
  localparam logic [TW-1:0] MING = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAXG = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] Y2R = TW'(Y2R_DELAY - 1);
  localparam logic [TW-1:0] R2G = TW'(R2G_DELAY - 1);
  if (N_APPR < 2 || N_APPR > 16 || HOME < 0 || HOME >= N_APPR || MIN_GREEN < 1 ||
      MAX_GREEN < MIN_GREEN || Y2R_DELAY < 1 || R2G_DELAY < 1 || MAX_GREEN >= 2**TW ||
      Y2R_DELAY >= 2**TW || R2G_DELAY >= 2**TW) begin : g_bad_params
    $error("multi_approach_tlc: illegal parameter set");
  end
  phase_t ph, ph_nx;
  logic [AW-1:0] act, act_nx, pick_g, start;
  logic [TW-1:0] timer;
  logic [N_APPR-1:0] oh, set, clr, dem_nx;
  logic pick_v, other_dem, go_y;
  logic [1:0] lamp;
  assign start = (act == AW'(N_APPR - 1)) ? '0 : act + 1'b1;
  tlc_rr_pick #(.N(N_APPR), .W(AW)) u_pick (
    .req(demand), .start(start), .dflt(HOME_I), .grant(pick_g), .valid(pick_v)
  );
  assign oh = N_APPR'(1) << act;
  assign other_dem = |(demand & ~oh);
  assign go_y = timer >= MING &&
                ((other_dem && (!sensor[act] || timer >= MAXG)) || (act != HOME_I && !sensor[act]));
  always_comb begin
    ph_nx = ph;
    act_nx = act;
    if (ph == PH_GREEN) begin
      if (go_y) ph_nx = PH_YELLOW;
    end else if (ph == PH_YELLOW) begin
      if (timer == Y2R) ph_nx = PH_ALLRED;
    end else if (timer == R2G) begin
      ph_nx = PH_GREEN;
      act_nx = pick_v ? pick_g : HOME_I;
    end
    set = sensor & ~((ph == PH_GREEN) ? oh : '0);
    // the approach being granted drops its demand even if its sensor is still high
    clr = (ph != PH_GREEN && ph_nx == PH_GREEN) ? N_APPR'(1) << act_nx : '0;
    dem_nx = (demand | set) & ~clr;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      ph <= PH_GREEN;
      act <= HOME_I;
      timer <= '0;
      demand <= '0;
    end else begin
      ph <= ph_nx;
      act <= act_nx;
      timer <= (ph_nx != ph) ? '0 : (&timer ? timer : timer + 1'b1);
      demand <= dem_nx;
    end
  end
  assign lamp = (ph == PH_GREEN) ? GREEN : (ph == PH_YELLOW) ? YELLOW : RED;
  always_comb begin
    lights = '0;
    for (int j = 0; j < N_APPR; j++) lights[2*j+:2] = (act == AW'(j)) ? lamp : RED;
  end
  assign active = act;
  assign phase = ph;
endmodule

// File: tb/tb_multi_approach_tlc.sv
// tb_multi_approach_tlc: directed checks of sequencing, timing, round robin and clear
module tb_multi_approach_tlc;
  logic clk = 1'b0;
  logic clear = 1'b1;
  logic [3:0] sensor = '0;
  logic [7:0] lights;
  logic [1:0] active;
  logic [1:0] phase;
  logic [3:0] demand;
  int errors = 0;
  int checks = 0;
  multi_approach_tlc dut (
    .clock(clk), .clear(clear), .sensor(sensor), .lights(lights),
    .active(active), .phase(phase), .demand(demand)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      int nr;
      @(posedge clk);
      #1;
      nr = 0;
      for (int j = 0; j < 4; j++) if (lights[2*j+:2] != 2'd0) nr++;
      chk("safety", 32'(nr <= 1), 32'd1);
    end
  endtask
  initial begin
    // idle rest on HOME
    tick(1);
    clear = 1'b0;
    chk("rst_lights", lights, 8'h02);
    chk("rst_phase", phase, 0);
    chk("rst_active", active, 0);
    chk("rst_demand", demand, 0);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("idle_phase", phase, 0);
      chk("idle_lights", lights, 8'h02);
      chk("idle_demand", demand, 0);
    end
    // min green then sequence to approach 2
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    sensor = 4'b0100;
    tick(1);
    sensor = '0;
    chk("mg_demand", demand, 4'b0100);
    tick(6);
    chk("mg_green7", phase, 0);
    tick(1);
    chk("mg_yellow", phase, 1);
    chk("mg_ylights", lights, 8'h01);
    tick(2);
    chk("mg_y3", phase, 1);
    tick(1);
    chk("mg_allred", phase, 2);
    chk("mg_rlights", lights, 8'h00);
    tick(1);
    chk("mg_ar2", phase, 2);
    tick(1);
    chk("mg_g2_phase", phase, 0);
    chk("mg_g2_active", active, 2);
    chk("mg_g2_lights", lights, 8'h20);
    chk("mg_g2_demand", demand, 0);
    // max green with home sensor held
    clear = 1'b1;
    sensor = 4'b0001;
    tick(1);
    clear = 1'b0;
    sensor = 4'b0011;
    tick(1);
    sensor = 4'b0001;
    chk("mx_demand", demand, 4'b0010);
    tick(30);
    chk("mx_green31", phase, 0);
    chk("mx_glights", lights, 8'h02);
    tick(1);
    chk("mx_yellow", phase, 1);
    tick(3);
    chk("mx_allred", phase, 2);
    tick(2);
    chk("mx_g1_phase", phase, 0);
    chk("mx_g1_active", active, 1);
    chk("mx_g1_lights", lights, 8'h08);
    chk("mx_g1_demand", demand, 4'b0001);
    // round robin skip and wrap from approach 3
    clear = 1'b1;
    sensor = '0;
    tick(1);
    clear = 1'b0;
    sensor = 4'b1000;
    tick(1);
    sensor = '0;
    tick(12);
    chk("rr_g3_active", active, 3);
    chk("rr_g3_lights", lights, 8'h80);
    sensor = 4'b0101;
    tick(1);
    sensor = '0;
    chk("rr_demand", demand, 4'b0101);
    tick(7);
    chk("rr_y3_phase", phase, 1);
    chk("rr_y3_lights", lights, 8'h40);
    tick(5);
    chk("rr_wrap_active", active, 0);
    chk("rr_wrap_phase", phase, 0);
    chk("rr_wrap_demand", demand, 4'b0100);
    tick(13);
    chk("rr_g2_active", active, 2);
    chk("rr_g2_phase", phase, 0);
    chk("rr_g2_demand", demand, 0);
    // gap-out from approach 1 back to home
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    sensor = 4'b0010;
    tick(1);
    sensor = '0;
    tick(10);
    chk("go_allred", phase, 2);
    sensor = 4'b0010;
    tick(2);
    chk("go_g1_active", active, 1);
    chk("go_g1_phase", phase, 0);
    chk("go_g1_demand", demand, 0);
    tick(10);
    chk("go_hold", phase, 0);
    sensor = '0;
    tick(1);
    chk("go_yellow", phase, 1);
    chk("go_ylights", lights, 8'h04);
    tick(3);
    chk("go_allred2", phase, 2);
    tick(2);
    chk("go_home_active", active, 0);
    chk("go_home_lights", lights, 8'h02);
    // clear in the middle of yellow
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    sensor = 4'b0010;
    tick(1);
    sensor = '0;
    tick(7);
    chk("cl_y_entry", phase, 1);
    tick(1);
    chk("cl_y_t1", phase, 1);
    clear = 1'b1;
    sensor = 4'b1111;
    tick(1);
    clear = 1'b0;
    sensor = '0;
    chk("cl_phase", phase, 0);
    chk("cl_active", active, 0);
    chk("cl_demand", demand, 0);
    chk("cl_lights", lights, 8'h02);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
